// File: rtl/spike_pkt_framer.sv
// Write-side packet framer: emits SOF, LEN, payload, CHK, EOF into a 16-bit FIFO
// under fifo_full back-pressure, flagging payload/length mismatches.
module spike_pkt_framer #(
  parameter int unsigned        WIDTH     = 16,
  parameter int unsigned        LEN_WIDTH = 10,
  parameter logic [WIDTH-1:0]   SOF_WORD  = 16'hFAF1,
  parameter logic [WIDTH-1:0]   EOF_WORD  = 16'hF1FA
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [LEN_WIDTH-1:0] pkt_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 fifo_wr_en,
  output logic [WIDTH-1:0]     fifo_wr_data,
  input  logic                 fifo_full,
  output logic                 len_err,
  output logic [15:0]          frame_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_EOF
  } state_t;

  state_t               r_state;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0]     r_csum;
  logic [15:0]          r_frame_cnt;
  logic                 r_len_err;

  logic                 w_accept;
  logic [LEN_WIDTH-1:0] w_cnt_nxt;
  logic                 w_at_len;
  logic                 w_term;

  assign w_accept  = (r_state == ST_PAYLOAD) && in_valid && !fifo_full;
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_at_len  = (w_cnt_nxt == r_len);
  assign w_term    = in_last || w_at_len;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_csum      <= '0;
      r_frame_cnt <= '0;
      r_len_err   <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_valid) begin
            r_len   <= pkt_len;
            r_cnt   <= '0;
            r_csum  <= '0;
            r_state <= ST_SOF;
          end
        end
        ST_SOF: begin
          if (!fifo_full) r_state <= ST_LEN;
        end
        ST_LEN: begin
          if (!fifo_full) r_state <= (r_len != '0) ? ST_PAYLOAD : ST_CHK;
        end
        ST_PAYLOAD: begin
          if (w_accept) begin
            r_csum <= r_csum + in_data;
            r_cnt  <= w_cnt_nxt;
            if (w_term) begin
              r_state   <= ST_CHK;
              // word count never exceeds len, so a mismatch is exactly last XOR at-length
              r_len_err <= in_last ^ w_at_len;
            end
          end
        end
        ST_CHK: begin
          if (!fifo_full) r_state <= ST_EOF;
        end
        ST_EOF: begin
          if (!fifo_full) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    case (r_state)
      ST_SOF: begin
        fifo_wr_en   = !fifo_full;
        fifo_wr_data = SOF_WORD;
      end
      ST_LEN: begin
        fifo_wr_en   = !fifo_full;
        fifo_wr_data = {{(WIDTH-LEN_WIDTH){1'b0}}, r_len};
      end
      ST_PAYLOAD: begin
        fifo_wr_en   = in_valid && !fifo_full;
        fifo_wr_data = in_data;
      end
      ST_CHK: begin
        fifo_wr_en   = !fifo_full;
        fifo_wr_data = r_csum;
      end
      ST_EOF: begin
        fifo_wr_en   = !fifo_full;
        fifo_wr_data = EOF_WORD;
      end
      default: begin
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
      end
    endcase
  end

  assign start_ready = (r_state == ST_IDLE);
  assign in_ready    = (r_state == ST_PAYLOAD) && !fifo_full;
  assign len_err     = r_len_err;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_spike_pkt_framer.sv
// Directed bench for spike_pkt_framer: frames are captured from the FIFO write port
// and compared against hand-computed word sequences.
module tb_spike_pkt_framer;

  logic        clk;
  logic        rstn;
  logic        start_valid;
  logic        start_ready;
  logic [9:0]  pkt_len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic        fifo_full;
  logic        len_err;
  logic [15:0] frame_cnt;

  spike_pkt_framer #(
    .WIDTH     (16),
    .LEN_WIDTH (10),
    .SOF_WORD  (16'hFAF1),
    .EOF_WORD  (16'hF1FA)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .pkt_len      (pkt_len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .len_err      (len_err),
    .frame_cnt    (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [15:0] wq[$];
  int          tq[$];
  logic [15:0] exp_q[$];
  int          cyc = 0;
  int          err_cnt, rdy_cnt, wr_full_viol, stall_chg, acc;
  logic        prev_full = 1'b0;
  logic [15:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rstn) begin
      if (fifo_wr_en) begin
        wq.push_back(fifo_wr_data);
        tq.push_back(cyc);
      end
      if (fifo_wr_en && fifo_full) wr_full_viol++;
      if (fifo_full && prev_full && (fifo_wr_data != prev_data)) stall_chg++;
      if (len_err) err_cnt++;
      if (in_ready) rdy_cnt++;
      prev_full = fifo_full;
      prev_data = fifo_wr_data;
    end
  end

  task automatic run_frame(input logic [9:0] len, input int nw,
                           input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input int last_at,
                           input logic [31:0] mask);
    logic done;
    wq.delete(); tq.delete();
    err_cnt = 0; rdy_cnt = 0; wr_full_viol = 0; stall_chg = 0; acc = 0;
    @(posedge clk); #1;
    start_valid = 1'b1; pkt_len = len; fifo_full = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      fifo_full = (c < 32) ? mask[c] : 1'b0;
      in_valid  = (acc < nw);
      in_data   = (acc == 0) ? w0 : (acc == 1) ? w1 : w2;
      in_last   = (acc == last_at);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      if (start_ready) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0; in_last = 1'b0; fifo_full = 1'b0;
    if (!done) check("frame_timeout", 32'd1, 32'd0);
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_nwords"}, wq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
      check($sformatf("%s_w%0d", tag, i), wq[i], exp_q[i]);
  endtask

  initial begin
    rstn = 1'b0; start_valid = 1'b0; pkt_len = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; fifo_full = 1'b0;
    #23;
    check("rst_start_ready", start_ready, 1);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_len_err", len_err, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rstn = 1'b1;

    // nominal
    run_frame(10'd3, 3, 16'h0001, 16'h0002, 16'h0003, 2, 32'h0);
    exp_q = '{16'hFAF1, 16'h0003, 16'h0001, 16'h0002, 16'h0003, 16'h0006, 16'hF1FA};
    compare_frame("nom");
    if (tq.size() == 7) check("nom_span", tq[6] - tq[0], 6);
    check("nom_frame_cnt", frame_cnt, 1);
    check("nom_len_err", err_cnt, 0);

    // zero length
    run_frame(10'd0, 0, 16'h0, 16'h0, 16'h0, -1, 32'h0);
    exp_q = '{16'hFAF1, 16'h0000, 16'h0000, 16'hF1FA};
    compare_frame("zero");
    check("zero_in_ready", rdy_cnt, 0);
    check("zero_frame_cnt", frame_cnt, 2);

    // back-pressure: full at cycles 1-3 (LEN) and 7-8 (mid-payload)
    run_frame(10'd3, 3, 16'h0001, 16'h0002, 16'h0003, 2, 32'h0000_018E);
    exp_q = '{16'hFAF1, 16'h0003, 16'h0001, 16'h0002, 16'h0003, 16'h0006, 16'hF1FA};
    compare_frame("bp");
    check("bp_wr_while_full", wr_full_viol, 0);
    check("bp_stall_data_change", stall_chg, 0);
    check("bp_frame_cnt", frame_cnt, 3);
    check("bp_len_err", err_cnt, 0);

    // early last
    run_frame(10'd4, 2, 16'h8000, 16'h8001, 16'h0, 1, 32'h0);
    exp_q = '{16'hFAF1, 16'h0004, 16'h8000, 16'h8001, 16'h0001, 16'hF1FA};
    compare_frame("early");
    check("early_len_err", err_cnt, 1);
    check("early_frame_cnt", frame_cnt, 4);

    // missing last: a third word stays offered but must not be taken
    run_frame(10'd2, 3, 16'h1111, 16'h2222, 16'h3333, -1, 32'h0);
    exp_q = '{16'hFAF1, 16'h0002, 16'h1111, 16'h2222, 16'h3333, 16'hF1FA};
    compare_frame("miss");
    check("miss_len_err", err_cnt, 1);
    check("miss_accepted", acc, 2);
    check("miss_in_ready_cycles", rdy_cnt, 2);
    check("miss_in_ready_idle", in_ready, 0);
    check("miss_frame_cnt", frame_cnt, 5);

    // reset in the middle of a payload
    @(posedge clk); #1;
    start_valid = 1'b1; pkt_len = 10'd5;
    @(posedge clk); #1;
    start_valid = 1'b0; in_valid = 1'b1; in_data = 16'h00AA;
    repeat (4) @(posedge clk);
    #3;
    check("pre_rst_in_ready", in_ready, 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_wr_en", fifo_wr_en, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_start_ready", start_ready, 1);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    check("mid_rst_len_err", len_err, 0);
    in_valid = 1'b0;
    @(posedge clk); #2;
    rstn = 1'b1;
    run_frame(10'd3, 3, 16'h0001, 16'h0002, 16'h0003, 2, 32'h0);
    exp_q = '{16'hFAF1, 16'h0003, 16'h0001, 16'h0002, 16'h0003, 16'h0006, 16'hF1FA};
    compare_frame("post_rst");
    check("post_rst_frame_cnt", frame_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_pkt_framer.md
Name: spike_pkt_framer

Overview:
- Write-side packet framer that feeds a 16-bit synchronous FIFO.
- Its frames use start marker 16'hFAF1 and end marker 16'hF1FA.
- It accepts a packet descriptor and a stream of 16-bit payload words from the core, and emits each frame into the FIFO write port: SOF, LEN, payload, CHK, EOF.
- It obeys FIFO full back-pressure and reports framing errors and a frame count.

Parameters:
- WIDTH, 16, data word width; must be 16 because the marker values are fixed.
- LEN_WIDTH, 10, width of the declared payload length; maximum payload is 2^LEN_WIDTH-1 words.
- SOF_WORD, 16'hFAF1, start-of-frame marker.
- EOF_WORD, 16'hF1FA, end-of-frame marker.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- start_valid  input  1  a packet descriptor is presented.
- start_ready  output  1  the framer is able to accept a descriptor.
- pkt_len  input  LEN_WIDTH  declared payload word count, sampled on the start handshake.
- in_valid  input  WIDTH/16 n/a: 1  payload word valid.
- in_ready  output  1  payload word accepted this cycle.
- in_data  input  WIDTH  payload word.
- in_last  input  1  marks the final payload word.
- fifo_wr_en  output  1  FIFO write strobe.
- fifo_wr_data  output  WIDTH  FIFO write data.
- fifo_full  input  1  FIFO full flag.
- len_err  output  1  one-cycle pulse when a framing length mismatch is detected.
- frame_cnt  output  16  count of completed frames; wraps modulo 2^16.

Behaviour:
- Reset (asynchronous, rstn=0):
  - state=IDLE; all counters, the checksum and frame_cnt are 0; len_err=0.
  - Because state is IDLE, fifo_wr_en=0 and in_ready=0.
  - Reset mid-frame abandons the frame with no EOF written.
- States: IDLE, SOF, LEN, PAYLOAD, CHK, EOF.
- IDLE:
  - start_ready=1 only in IDLE.
  - When start_valid=1, latch pkt_len into len_reg, clear word_cnt and csum, and go to SOF.
- Write rule (SOF, LEN, CHK, EOF):
  - fifo_wr_en = !fifo_full. fifo_wr_en and fifo_wr_data are combinational from state.
  - The state advances only on a cycle where the write occurs.
  - While fifo_full=1 the framer holds its state and fifo_wr_data stays stable.
- Word written per state:
  - SOF writes SOF_WORD, then goes to LEN.
  - LEN writes len_reg zero-extended to 16 bits. Next state is PAYLOAD if len_reg!=0, otherwise CHK.
  - PAYLOAD: see below.
  - CHK writes csum, then goes to EOF.
  - EOF writes EOF_WORD, increments frame_cnt (wraps), and goes to IDLE.
- PAYLOAD handshake:
  - in_ready = !fifo_full.
  - On in_valid && in_ready: fifo_wr_en=1, fifo_wr_data=in_data, csum <= csum + in_data (mod 2^16), word_cnt <= word_cnt+1.
  - fifo_wr_en=0 on cycles with no accepted word.
- Payload termination happens on the first accepted word where in_last=1 or word_cnt+1==len_reg; the next state is CHK.
  - Early last: in_last=1 with word_cnt+1<len_reg → len_err pulse on the next cycle.
  - Missing last: word_cnt+1==len_reg with in_last=0 → len_err pulse on the next cycle. Further payload words are not accepted until the next frame.
- LEN field always carries the declared length, even when len_err fires.
- Latency and throughput:
  - With fifo_full=0, the SOF write occurs the cycle after the start handshake.
  - A frame of N payload words with in_valid held high takes N+4 write cycles.
  - IDLE lasts at least one cycle between frames.
- Words are never written while fifo_full=1, so no FIFO overflow is possible.
- Payload words equal to SOF_WORD or EOF_WORD pass through unmodified; the downstream reader uses LEN to delimit the frame.

Test Plan:
- Nominal frame: pkt_len=3, payload 0001,0002,0003 with in_last on the third word, fifo_full=0 → FIFO receives FAF1,0003,0001,0002,0003,0006,F1FA on 7 consecutive cycles; frame_cnt=1; len_err never asserted.
- Zero length: pkt_len=0 → writes FAF1,0000,0000,F1FA; in_ready is never asserted.
- Back-pressure: same frame as the nominal case, with fifo_full=1 for 3 cycles during LEN and 2 cycles mid-payload → identical word sequence, no writes while full, wr_data stable during stalls.
- Early last: pkt_len=4, in_last on the 2nd word (0x8000, 0x8001) → FAF1,0004,8000,8001,0001,F1FA; one len_err pulse.
- Missing last: pkt_len=2, in_last never asserted → frame closes after 2 words; one len_err pulse; in_ready=0 during CHK, EOF and IDLE.
- Reset and wrap:
  - Assert rstn=0 during PAYLOAD → all outputs return to reset values immediately; the next frame starts cleanly with FAF1.
  - Run 65536 frames → frame_cnt wraps to 0.
